locked_adder_sched: RTL and testbench

Controller that shares one external key-locked 32-bit adder between NUM_REQ requesters. It loads the 64-bit unlock key in chunks and holds it, which makes it the single owner of the key bus. It arbitrates operand requests round-robin and pipelines operands and results around the combinational adder. Responses return tagged with the requester ID. It sits between the client bus and the locked adder netlist.

---
 rtl/locked_adder_pkg.sv | 22 ++
 rtl/locked_adder_sched_arb.sv | 46 ++++
 rtl/locked_adder_sched.sv | 166 ++++++++++++++++
 tb/tb_locked_adder_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/locked_adder_pkg.sv
// Shared types and defaults for the key-locked adder scheduler.
package locked_adder_pkg;

   // Controller life cycle: no key, key being loaded, in service, draining before erase
   typedef enum logic [1:0] {
      EMPTY,
      LOAD,
      RUN,
      DRAIN
   } sched_state_e;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_KEY_W     = 64;
   localparam int DEF_KEY_CHUNK = 8;

   // Width of an index into n items, never narrower than one bit
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/locked_adder_sched_arb.sv
// Round-robin arbiter: searches from a rotating pointer and grants one requester.
module rr_arbiter
   import locked_adder_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W = id_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               enable,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   logic [ID_W-1:0] ptr_q;
   logic            found;
   int              idx;

   // Pick the first active requester at or after the pointer, wrapping around
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (enable && !found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

   // Move the pointer just past the requester that was served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (advance) begin
         ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/locked_adder_sched.sv
// Scheduler owning the unlock key of a shared combinational locked adder.
// Loads the key in chunks, arbitrates requesters round-robin and wraps the
// adder in a two-stage operand/result pipeline with id-tagged responses.
module locked_adder_sched
   import locked_adder_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int KEY_W     = DEF_KEY_W,
   parameter int KEY_CHUNK = DEF_KEY_CHUNK,
   localparam int ID_W = id_width(NUM_REQ)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      key_wr_i,
   input  logic [KEY_CHUNK-1:0]      key_data_i,
   input  logic                      key_clear_i,
   output logic                      key_loaded_o,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [ID_W-1:0]           resp_id_o,
   output logic [DATA_W:0]           resp_sum_o,
   output logic [DATA_W-1:0]         adder_a_o,
   output logic [DATA_W-1:0]         adder_b_o,
   output logic [KEY_W-1:0]          adder_key_o,
   input  logic [DATA_W:0]           adder_sum_i
);

   localparam int NUM_CHUNK = KEY_W / KEY_CHUNK;
   localparam int CNT_W = id_width(NUM_CHUNK);
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNK - 1);

   sched_state_e       state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [KEY_W-1:0]   key_q;
   logic               key_loaded_q;

   logic               s1_valid_q;
   logic [DATA_W-1:0]  s1_a_q;
   logic [DATA_W-1:0]  s1_b_q;
   logic [ID_W-1:0]    s1_id_q;

   logic               s2_valid_q;
   logic [DATA_W:0]    s2_sum_q;
   logic [ID_W-1:0]    s2_id_q;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               arb_enable;
   logic               handshake;
   logic               resp_fire;
   logic               s1_advance;

   assign resp_fire  = s2_valid_q & resp_ready_i;
   assign s1_advance = s1_valid_q & (~s2_valid_q | resp_fire);
   assign arb_enable = (state_q == RUN) & ~key_clear_i & (~s1_valid_q | s1_advance);
   assign handshake  = |grant;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .req     (req_valid_i),
      .enable  (arb_enable),
      .advance (handshake),
      .grant   (grant),
      .grant_id(grant_id)
   );

   // Key life cycle: collect chunks, serve, then erase once the pipeline is empty
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         cnt_q        <= '0;
         key_q        <= '0;
         key_loaded_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (key_wr_i) begin
                  key_q[KEY_CHUNK-1:0] <= key_data_i;
                  cnt_q                <= CNT_W'(1);
                  state_q              <= LOAD;
               end
            end
            LOAD: begin
               if (key_clear_i) begin
                  key_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= EMPTY;
               end else if (key_wr_i) begin
                  key_q[cnt_q*KEY_CHUNK +: KEY_CHUNK] <= key_data_i;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_CHUNK) begin
                     state_q      <= RUN;
                     key_loaded_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (key_clear_i) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (!s1_valid_q && !s2_valid_q) begin
                  key_q        <= '0;
                  cnt_q        <= '0;
                  key_loaded_q <= 1'b0;
                  state_q      <= EMPTY;
               end
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase
      end
   end

   // Operand stage: capture the granted requester's operands, hold while blocked
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
      end else if (handshake) begin
         s1_valid_q <= 1'b1;
         s1_a_q     <= req_a_i[grant_id*DATA_W +: DATA_W];
         s1_b_q     <= req_b_i[grant_id*DATA_W +: DATA_W];
         s1_id_q    <= grant_id;
      end else if (s1_advance) begin
         s1_valid_q <= 1'b0;
      end
   end

   // Result stage: register the adder output and hold it until accepted
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_id_q    <= '0;
      end else if (s1_advance) begin
         s2_valid_q <= 1'b1;
         s2_sum_q   <= adder_sum_i;
         s2_id_q    <= s1_id_q;
      end else if (resp_fire) begin
         s2_valid_q <= 1'b0;
      end
   end

   assign req_ready_o  = grant;
   assign key_loaded_o = key_loaded_q;
   assign adder_key_o  = key_q;
   assign adder_a_o    = s1_a_q;
   assign adder_b_o    = s1_b_q;
   assign resp_valid_o = s2_valid_q;
   assign resp_id_o    = s2_id_q;
   assign resp_sum_o   = s2_sum_q;

endmodule

// File: tb/tb_locked_adder_sched.sv
// Scoreboard bench for locked_adder_sched with an in-bench locked adder model.
module tb_locked_adder_sched;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int KW = 64;
   localparam int KC = 8;
   localparam logic [KW-1:0] KEY_GOOD = 64'h0807060504030201;

   typedef struct {
      logic [1:0]  id;
      logic [DW:0] sum;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_ni;
   logic           key_wr_i;
   logic [KC-1:0]  key_data_i;
   logic           key_clear_i;
   logic           key_loaded_o;
   logic [NR-1:0]  req_valid_i;
   logic [NR-1:0]  req_ready_o;
   logic [NR*DW-1:0] req_a_i;
   logic [NR*DW-1:0] req_b_i;
   logic           resp_valid_o;
   logic           resp_ready_i;
   logic [1:0]     resp_id_o;
   logic [DW:0]    resp_sum_o;
   logic [DW-1:0]  adder_a_o;
   logic [DW-1:0]  adder_b_o;
   logic [KW-1:0]  adder_key_o;
   logic [DW:0]    adder_sum_i;

   exp_t          exp_q[$];
   int            grant_log[$];
   logic [DW-1:0] op_a[NR];
   logic [DW-1:0] op_b[NR];
   logic [NR-1:0] vld;
   logic [NR-1:0] hs_mask;
   int            stim_mode;
   int            rr_ptr;
   int            total = 0;
   int            bad = 0;

   locked_adder_sched dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .key_wr_i    (key_wr_i),
      .key_data_i  (key_data_i),
      .key_clear_i (key_clear_i),
      .key_loaded_o(key_loaded_o),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .resp_valid_o(resp_valid_o),
      .resp_ready_i(resp_ready_i),
      .resp_id_o   (resp_id_o),
      .resp_sum_o  (resp_sum_o),
      .adder_a_o   (adder_a_o),
      .adder_b_o   (adder_b_o),
      .adder_key_o (adder_key_o),
      .adder_sum_i (adder_sum_i)
   );

   // Locked adder: adds only when the correct key is presented, garbage otherwise
   assign adder_sum_i = (adder_key_o == KEY_GOOD) ? ({1'b0, adder_a_o} + {1'b0, adder_b_o})
                                                  : {1'b0, adder_a_o ^ adder_b_o};

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic packReqs();
      for (int i = 0; i < NR; i++) begin
         req_valid_i[i]         = vld[i];
         req_a_i[i*DW +: DW]    = op_a[i];
         req_b_i[i*DW +: DW]    = op_b[i];
      end
   endtask

   // Advance one clock and refresh requester operands according to the mode
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         if (stim_mode == 0) begin
            if (hs_mask[i]) vld[i] = 1'b0;
         end else if (stim_mode == 1) begin
            if (hs_mask[i] || !vld[i]) begin
               op_a[i] = $urandom;
               op_b[i] = $urandom;
            end
            vld[i] = 1'b1;
         end else begin
            if (hs_mask[i] || !vld[i]) begin
               vld[i]  = 1'($urandom_range(0, 1));
               op_a[i] = $urandom;
               op_b[i] = $urandom;
            end
         end
      end
      if (stim_mode == 2) resp_ready_i = ($urandom_range(0, 3) != 0);
      packReqs();
   endtask

   task automatic sampleMid();
      @(negedge clk);
      #1;
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_key_loaded"}, key_loaded_o, 0);
      checkOutput({tag, "_req_ready"}, req_ready_o, 0);
      checkOutput({tag, "_resp_valid"}, resp_valid_o, 0);
      checkOutput({tag, "_resp_id"}, resp_id_o, 0);
      checkOutput({tag, "_resp_sum"}, resp_sum_o, 0);
      checkOutput({tag, "_adder_a"}, adder_a_o, 0);
      checkOutput({tag, "_adder_b"}, adder_b_o, 0);
      checkOutput({tag, "_adder_key"}, adder_key_o, 0);
   endtask

   task automatic loadKey();
      for (int k = 0; k < KW / KC; k++) begin
         applyStimulus();
         key_wr_i   = 1'b1;
         key_data_i = KC'(k + 1);
         sampleMid();
         checkOutput("loaded_during_load", key_loaded_o, 0);
         checkOutput("no_grant_before_key", req_ready_o, 0);
      end
      applyStimulus();
      key_wr_i = 1'b0;
      sampleMid();
      checkOutput("key_loaded_after_last", key_loaded_o, 1);
      checkOutput("adder_key_value", adder_key_o, KEY_GOOD);
   endtask

   // Handshake recorder: round-robin model check and expected-result push
   initial begin
      int win;
      int gid;
      rr_ptr  = 0;
      hs_mask = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            exp_q.delete();
            rr_ptr  = 0;
            hs_mask = '0;
         end else begin
            hs_mask = req_ready_o & req_valid_i;
            if (req_ready_o != '0) begin
               win = -1;
               for (int k = 0; k < NR; k++) begin
                  if (win < 0 && req_valid_i[(rr_ptr + k) % NR]) win = (rr_ptr + k) % NR;
               end
               gid = 0;
               for (int i = 0; i < NR; i++) if (req_ready_o[i]) gid = i;
               checkOutput("grant_onehot", $countones(req_ready_o), 1);
               checkOutput("rr_winner", 64'(gid), 64'(win));
               exp_q.push_back('{id: 2'(gid), sum: {1'b0, op_a[gid]} + {1'b0, op_b[gid]}});
               grant_log.push_back(gid);
               rr_ptr = (gid + 1) % NR;
            end
         end
      end
   end

   // Response monitor: in-order pop and compare, plus hold-stability under backpressure
   initial begin
      exp_t        e;
      logic        prev_hold;
      logic [1:0]  prev_id;
      logic [DW:0] prev_sum;
      prev_hold = 1'b0;
      prev_id   = '0;
      prev_sum  = '0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               checkOutput("hold_valid", resp_valid_o, 1);
               checkOutput("hold_id", resp_id_o, prev_id);
               checkOutput("hold_sum", resp_sum_o, prev_sum);
            end
            if (resp_valid_o && resp_ready_i) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("[TB] FAIL unexpected_resp: got id %0d sum %0h expected none", resp_id_o, resp_sum_o);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("resp_id", resp_id_o, e.id);
                  checkOutput("resp_sum", resp_sum_o, e.sum);
               end
            end
            prev_hold = resp_valid_o && !resp_ready_i;
            prev_id   = resp_id_o;
            prev_sum  = resp_sum_o;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  start;
      bit  done;
      stim_mode    = 0;
      rst_ni       = 1'b1;
      key_wr_i     = 1'b0;
      key_data_i   = '0;
      key_clear_i  = 1'b0;
      resp_ready_i = 1'b1;
      vld          = '0;
      for (int i = 0; i < NR; i++) begin
         op_a[i] = $urandom;
         op_b[i] = $urandom;
      end
      packReqs();
      #1 rst_ni = 1'b0;
      #1 checkZeroOutputs("rst_init");
      sampleMid();
      sampleMid();
      applyStimulus();
      rst_ni = 1'b1;

      // Request while no key: must not be granted
      vld[0]  = 1'b1;
      op_a[0] = 32'd5;
      op_b[0] = 32'd7;
      packReqs();
      for (int c = 0; c < 3; c++) begin
         sampleMid();
         checkOutput("no_grant_empty", req_ready_o, 0);
         applyStimulus();
      end
      loadKey();
      checkOutput("first_grant", hs_mask, 4'b0001);
      applyStimulus();
      sampleMid();
      checkOutput("latency_t1_valid", resp_valid_o, 0);
      applyStimulus();
      sampleMid();
      checkOutput("latency_t2_valid", resp_valid_o, 1);
      checkOutput("first_sum", resp_sum_o, 12);
      checkOutput("first_id", resp_id_o, 0);

      // All requesters continuously valid
      stim_mode = 1;
      start = rr_ptr;
      grant_log.delete();
      for (int c = 0; c < 8; c++) begin
         applyStimulus();
         sampleMid();
         checkOutput("grant_every_cycle", |hs_mask, 1);
         if (c >= 2) checkOutput("back_to_back", resp_valid_o, 1);
      end
      for (int k = 0; k < 6; k++) begin
         checkOutput("grant_order", 64'(grant_log[k]), 64'((start + k) % NR));
      end

      // Backpressure for three cycles with the pipeline full
      for (int c = 0; c < 3; c++) begin
         applyStimulus();
         resp_ready_i = 1'b0;
         sampleMid();
         checkOutput("bp_no_grant", req_ready_o, 0);
      end
      applyStimulus();
      resp_ready_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         sampleMid();
         applyStimulus();
      end

      // Key clear with operations in flight
      key_clear_i = 1'b1;
      sampleMid();
      checkOutput("clear_blocks_grant", req_ready_o, 0);
      applyStimulus();
      key_clear_i = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         sampleMid();
         if (!key_loaded_o) done = 1'b1;
         else begin
            checkOutput("drain_no_grant", req_ready_o, 0);
            applyStimulus();
         end
      end
      checkOutput("drain_timeout", done, 1);
      checkOutput("drain_key_zero", adder_key_o, 0);
      checkOutput("drain_delivered", exp_q.size(), 0);
      checkOutput("drain_no_grant_empty", req_ready_o, 0);
      stim_mode = 0;
      vld = '0;
      packReqs();

      // Reset in the middle of a key load
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         key_wr_i   = 1'b1;
         key_data_i = KC'(k + 1);
      end
      applyStimulus();
      key_wr_i = 1'b0;
      rst_ni = 1'b0;
      #1 checkZeroOutputs("rst_load");
      sampleMid();
      sampleMid();
      applyStimulus();
      rst_ni = 1'b1;
      loadKey();

      // Reset with the pipeline busy, then confirm nothing stale comes out
      stim_mode = 1;
      for (int c = 0; c < 4; c++) begin
         applyStimulus();
         sampleMid();
      end
      applyStimulus();
      rst_ni = 1'b0;
      #1 checkZeroOutputs("rst_pipe");
      stim_mode = 0;
      vld = '0;
      packReqs();
      sampleMid();
      sampleMid();
      applyStimulus();
      rst_ni = 1'b1;
      for (int c = 0; c < 5; c++) begin
         sampleMid();
         checkOutput("no_stale_resp", resp_valid_o, 0);
         applyStimulus();
      end
      loadKey();

      // Randomised traffic with random backpressure
      stim_mode = 2;
      for (int c = 0; c < 400; c++) applyStimulus();
      stim_mode = 0;
      vld = '0;
      packReqs();
      resp_ready_i = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
         applyStimulus();
         sampleMid();
         if (exp_q.size() == 0 && !resp_valid_o) done = 1'b1;
      end
      checkOutput("final_drain", done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
